lisnoc_router_out_arbiter: RTL

LISNOC_ROUTER_OUT_ARBITER -- requirements
Module: lisnoc_router_out_arbiter

---
 rtl/lisnoc_router_out_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/lisnoc_router_out_arbiter.sv
// Output arbiter for one router port: round-robin grant among inputs,
// packet-level locking on HEADER..LAST, and a one-entry output register.
module lisnoc_router_out_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ports*(flit_data_width+flit_type_width)-1:0] in_flit_i,
  input  logic [ports-1:0]                  in_valid_i,
  output logic [ports-1:0]                  in_ready_o,
  output logic [flit_data_width+flit_type_width-1:0] out_flit_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [ports-1:0]                  owner_o,
  output logic                              proto_err_o
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int lw = (ports > 1) ? $clog2(ports) : 1;

  localparam logic [flit_type_width-1:0] payload = 'b00;
  localparam logic [flit_type_width-1:0] header  = 'b01;
  localparam logic [flit_type_width-1:0] last    = 'b10;
  localparam logic [flit_type_width-1:0] single  = 'b11;

  typedef enum logic {
    idle,
    locked
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [lw-1:0]              last_q;
  logic [lw-1:0]              last_d;
  logic                       err_d;
  logic [lw-1:0]              gidx;
  logic                       found;
  logic [ports-1:0]           grant;
  logic                       can_accept;
  logic                       xfer;
  logic [flit_width-1:0]      sel_flit;
  logic [flit_type_width-1:0] ftype;

  assign can_accept = !out_valid_o || out_ready_i;
  assign sel_flit   = in_flit_i[int'(gidx)*flit_width +: flit_width];
  assign ftype      = sel_flit[flit_width-1 -: flit_type_width];
  assign xfer       = |(in_ready_o & in_valid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= idle;
      last_q      <= lw'(ports - 1);
      proto_err_o <= 1'b0;
      out_valid_o <= 1'b0;
      out_flit_o  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      proto_err_o <= err_d;
      if (xfer) begin
        out_valid_o <= 1'b1;
        out_flit_o  <= sel_flit;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (xfer) begin
      last_d = gidx;
      if (state_q == idle) begin
        unique case (1'b1)
          ftype == header: state_d = locked;
          ftype == single: state_d = idle;
          default:         err_d   = 1'b1;
        endcase
      end else begin
        unique case (1'b1)
          ftype == last:    state_d = idle;
          ftype == payload: state_d = locked;
          default:          err_d   = 1'b1;
        endcase
      end
    end
  end

  // Lock owner is always last_q, since the locking HEADER set it.
  always_comb begin
    logic [lw:0] sum;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    if (state_q == locked) begin
      gidx  = last_q;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= ports; k++) begin
        sum = {1'b0, last_q} + (lw+1)'(k);
        if (sum >= (lw+1)'(ports))
          sum = sum - (lw+1)'(ports);
        if (!found && in_valid_i[sum[lw-1:0]]) begin
          found = 1'b1;
          gidx  = sum[lw-1:0];
        end
      end
    end
    grant      = found ? (ports'(1) << gidx) : '0;
    in_ready_o = grant & {ports{can_accept && rst_n}};
    owner_o    = (state_q == locked) ? (ports'(1) << last_q) : '0;
  end

endmodule
